hc02_test_sequencer: RTL and testbench
======================================

Name: hc02_test_sequencer

Overview:
- Sequences a self-test of an external quad 2-input NOR package with 4 gates (74HC02 type) on the board.
- Drives all four truth-table vectors onto every gate in parallel and waits a programmable settle time.
- Samples the gate outputs through a synchroniser, compares them against the expected ~(a|b), and reports per-gate failures.
- Sits between the CPU-side start/status interface and the package's A/B/Y pins.

Parameters:
- N_GATES, 4, number of gates tested in parallel.
- SETTLE_CYCLES, 8, cycles spent in SETTLE per vector; must be >= 3 to cover the 2-FF synchroniser; legal range 3..15.
- CNT_W, 4, settle counter width; must hold SETTLE_CYCLES-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a test run; sampled in IDLE only.
- y_in  in  N_GATES  gate outputs from the package; asynchronous, passed through a 2-FF synchroniser.
- a_out  out  N_GATES  gate A inputs; registered.
- b_out  out  N_GATES  gate B inputs; registered.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  result of the last completed run; 1 = all gates correct.
- fail_mask  out  N_GATES  bit g set if gate g mismatched on any vector.
- err_count  out  3  number of vectors (0..4) with at least one mismatching gate.
- first_fail_vec  out  2  vector index {a,b} of the first failing vector; 0 if none.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset values: state=IDLE; a_out=0, b_out=0; busy=0, done=0, pass=0, fail_mask=0, err_count=0, first_fail_vec=0; synchroniser flops=0; vec=0; cnt=0.
- Vector order: vec 0..3 = {a,b} 00, 01, 10, 11. a_out = {N_GATES{vec[1]}}, b_out = {N_GATES{vec[0]}}.
- Expected result per vector: exp = {N_GATES{~(vec[1]|vec[0])}}, i.e. all-ones for vec 0, otherwise all-zeros.
- IDLE:
  - a_out/b_out held at 0.
  - On start=1: clear fail_mask, err_count and first_fail_vec; set pass=0, vec=0, cnt=0; load a_out/b_out for vec 0; go to SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to CHECK.
  - Outputs held stable.
- CHECK (1 cycle):
  - mism = y_sync ^ exp, where y_sync is the second synchroniser stage.
  - fail_mask |= mism.
  - If mism!=0: err_count+1; if err_count was 0, first_fail_vec=vec.
  - If vec==3, go to DONE.
  - Else vec+1, load a_out/b_out for the new vector in the same edge, cnt=0, go to SETTLE.
- DONE (1 cycle):
  - done=1, busy=0; pass=(fail_mask==0), registered here; a_out/b_out return to 0; go to IDLE.
- Latency:
  - If start is sampled at edge E0, busy is high from E0 to E0+4*(SETTLE_CYCLES+1).
  - done is high in the cycle following edge E0+4*(SETTLE_CYCLES+1), i.e. edge 36 at the default setting.
  - Total run is 4*(SETTLE_CYCLES+1)+1 cycles.
- Holding results: pass, fail_mask, err_count and first_fail_vec hold until the next accepted start.
- Boundary conditions:
  - start while busy or in DONE: ignored, with no restart and no result corruption.
  - start held high continuously: a new run starts in the IDLE cycle after DONE.
  - rst_n low mid-run: at the next edge all state returns to reset values. a_out/b_out drop to 0, no done pulse is issued, and results clear.
  - err_count saturates naturally at 4 and cannot wrap.
  - The synchroniser runs continuously, including in IDLE.

Test Plan:
- Ideal NOR model (y = ~(a|b), 2-cycle delay), start pulse at edge 0 -> busy 1 during edges 0..36; done pulse after edge 36; pass=1, fail_mask=0000, err_count=0, first_fail_vec=00.
- Gate 2 stuck-at-1 -> fail_mask=0100, err_count=3, first_fail_vec=01, pass=0.
- Gate 0 stuck-at-0 plus gate 3 wired as OR -> fail_mask=1001, err_count=4, first_fail_vec=00, pass=0.
- Extra start pulses at edges 5 and 20, then start held high through DONE -> first run completes unchanged; a second run begins in the IDLE cycle after DONE; results cleared at its start.
- rst_n low for one cycle at edge 15 of a run, with gate 1 faulty -> next cycle state IDLE, a_out=b_out=0000, busy=0, no done pulse, fail_mask=0000, pass=0.
- SETTLE_CYCLES=3 with a model delay of 2 cycles plus the synchroniser -> pass=1; model delay raised to 5 cycles -> mismatches detected and pass=0.

Source files
------------

// File: rtl/hc02_test_sequencer.sv
// rtl/hc02_test_sequencer.sv - self-test sequencer for a quad 2-input NOR (74HC02) package
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   start          run request, honoured in IDLE only
//   y_in           gate outputs from the package (asynchronous, 2-FF synchronised)
//   a_out, b_out   registered gate A/B drive
//   busy           high while settling/checking
//   done           one-cycle completion pulse
//   pass           1 when the last completed run saw no mismatch
//   fail_mask      per-gate sticky mismatch flags
//   err_count      number of vectors with at least one mismatching gate
//   first_fail_vec {a,b} index of the first failing vector
module hc02_test_sequencer #(
  parameter int N_GATES       = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_GATES-1:0] y_in,
  output logic [N_GATES-1:0] a_out,
  output logic [N_GATES-1:0] b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_GATES-1:0] fail_mask,
  output logic [2:0]         err_count,
  output logic [1:0]         first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nx;
  logic [1:0]         vec, vec_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [N_GATES-1:0] y_meta, y_sync;
  logic [N_GATES-1:0] a_nx, b_nx, mask_nx;
  logic               pass_nx;
  logic [2:0]         err_nx;
  logic [1:0]         first_nx;
  logic [1:0]         vec_inc;
  logic [N_GATES-1:0] exp_y, mism;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      y_meta         <= '0;
      y_sync         <= '0;
      a_out          <= '0;
      b_out          <= '0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else begin
      // Synchroniser is free-running so y_sync is already settled when a run starts.
      y_meta         <= y_in;
      y_sync         <= y_meta;
      state          <= state_nx;
      vec            <= vec_nx;
      cnt            <= cnt_nx;
      a_out          <= a_nx;
      b_out          <= b_nx;
      pass           <= pass_nx;
      fail_mask      <= mask_nx;
      err_count      <= err_nx;
      first_fail_vec <= first_nx;
    end
  end

  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    cnt_nx   = cnt;
    a_nx     = a_out;
    b_nx     = b_out;
    pass_nx  = pass;
    mask_nx  = fail_mask;
    err_nx   = err_count;
    first_nx = first_fail_vec;
    vec_inc  = vec + 2'd1;
    // NOR truth table: only vector 00 drives the outputs high.
    exp_y    = {N_GATES{~(vec[1] | vec[0])}};
    mism     = y_sync ^ exp_y;

    case (state)
      IDLE: begin
        a_nx = '0;
        b_nx = '0;
        if (start) begin
          mask_nx  = '0;
          err_nx   = '0;
          first_nx = '0;
          pass_nx  = 1'b0;
          vec_nx   = '0;
          cnt_nx   = '0;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_nx = CHECK;
      end
      CHECK: begin
        mask_nx = fail_mask | mism;
        if (mism != '0) begin
          // At most four vectors, so the 3-bit count can never wrap.
          err_nx = err_count + 3'd1;
          if (err_count == 3'd0) first_nx = vec;
        end
        if (vec == 2'd3) begin
          a_nx     = '0;
          b_nx     = '0;
          state_nx = DONE;
        end else begin
          vec_nx   = vec_inc;
          a_nx     = {N_GATES{vec_inc[1]}};
          b_nx     = {N_GATES{vec_inc[0]}};
          cnt_nx   = '0;
          state_nx = SETTLE;
        end
      end
      DONE: begin
        pass_nx  = (fail_mask == '0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hc02_test_sequencer.sv
// tb/tb_hc02_test_sequencer.sv - self-checking bench for hc02_test_sequencer
module tb_hc02_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] y_a, y_b;
  logic [3:0] a_out_a, b_out_a, fail_mask_a, a_out_b, b_out_b, fail_mask_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [2:0] err_a, err_b;
  logic [1:0] first_a, first_b;

  int vectors = 0;
  int miscompares = 0;

  // Package fault codes, 3 bits per gate: 0 NOR, 1 stuck0, 2 stuck1, 3 OR, 4 AND, 5 NAND, 6 XOR, 7 XNOR
  logic [11:0] fault_a = '0, fault_b = '0;
  // Package delay d: the synchroniser first captures a new drive d edges after it launches.
  int dly_a = 2, dly_b = 2;
  logic sel_b = 1'b0;

  hc02_test_sequencer #(.N_GATES(4), .SETTLE_CYCLES(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y_in(y_a),
    .a_out(a_out_a), .b_out(b_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_mask(fail_mask_a), .err_count(err_a), .first_fail_vec(first_a));

  hc02_test_sequencer #(.N_GATES(4), .SETTLE_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y_in(y_b),
    .a_out(a_out_b), .b_out(b_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_mask(fail_mask_b), .err_count(err_b), .first_fail_vec(first_b));

  function automatic logic gate_resp(input logic [2:0] f, input logic a, input logic b);
    case (f)
      3'd0: return ~(a | b);
      3'd1: return 1'b0;
      3'd2: return 1'b1;
      3'd3: return a | b;
      3'd4: return a & b;
      3'd5: return ~(a & b);
      3'd6: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [3:0] pkg(input logic [11:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] y;
    for (int g = 0; g < 4; g++) y[g] = gate_resp(f[3*g +: 3], a[g], b[g]);
    return y;
  endfunction

  // Package model: delay line of drive history feeding the faulty gates.
  logic [3:0] ha_a [16], hb_a [16], ha_b [16], hb_b [16];
  always @(posedge clk) begin
    ha_a[0] <= a_out_a; hb_a[0] <= b_out_a;
    ha_b[0] <= a_out_b; hb_b[0] <= b_out_b;
    for (int i = 1; i < 16; i++) begin
      ha_a[i] <= ha_a[i-1]; hb_a[i] <= hb_a[i-1];
      ha_b[i] <= ha_b[i-1]; hb_b[i] <= hb_b[i-1];
    end
  end

  always_comb begin
    if (dly_a <= 1) y_a = pkg(fault_a, a_out_a, b_out_a);
    else            y_a = pkg(fault_a, ha_a[dly_a-2], hb_a[dly_a-2]);
    if (dly_b <= 1) y_b = pkg(fault_b, a_out_b, b_out_b);
    else            y_b = pkg(fault_b, ha_b[dly_b-2], hb_b[dly_b-2]);
  end

  logic       o_busy, o_done, o_pass;
  logic [3:0] o_a, o_b, o_mask;
  logic [2:0] o_err;
  logic [1:0] o_first;
  assign o_busy  = sel_b ? busy_b      : busy_a;
  assign o_done  = sel_b ? done_b      : done_a;
  assign o_pass  = sel_b ? pass_b      : pass_a;
  assign o_a     = sel_b ? a_out_b     : a_out_a;
  assign o_b     = sel_b ? b_out_b     : b_out_a;
  assign o_mask  = sel_b ? fail_mask_b : fail_mask_a;
  assign o_err   = sel_b ? err_b       : err_a;
  assign o_first = sel_b ? first_b     : first_a;

  // Reference result {pass, fail_mask, err_count, first_fail_vec}. Each vector is held for s+1
  // cycles; the sample taken for vector v reflects whichever vector was driven s-1-d cycles after
  // v launched (before the run, the pins idle at 00).
  function automatic logic [9:0] model(input logic [11:0] f, input int d, input int s);
    logic [3:0] mask, mm;
    int err, first, off, src;
    logic sa, sb, expb;
    mask = '0; err = 0; first = 0;
    off = s - 1 - d;
    for (int v = 0; v < 4; v++) begin
      src = (off >= 0) ? v : v - ((-off + s) / (s + 1));
      if (src < 0) begin sa = 1'b0; sb = 1'b0; end
      else begin sa = src[1]; sb = src[0]; end
      expb = (v == 0);
      mm = '0;
      for (int g = 0; g < 4; g++) if (gate_resp(f[3*g +: 3], sa, sb) != expb) mm[g] = 1'b1;
      if (mm != '0) begin
        if (err == 0) first = v;
        err++;
        mask |= mm;
      end
    end
    return {(mask == '0), mask, 3'(err), 2'(first)};
  endfunction

  task automatic drive_start(input logic use_b, input logic v);
    if (use_b) start_b = v; else start_a = v;
  endtask

  // One full run: checks busy/done/drive cycle by cycle, then results in the IDLE cycle after DONE.
  // extra=1 adds start pulses at edges 5 and 20 and holds start from just before DONE onward.
  task automatic run_and_check(input logic use_b, input int extra, output logic [9:0] ref_res);
    int s, L, v;
    logic bad, st;
    logic [3:0] ea, eb;
    sel_b = use_b;
    s = use_b ? 3 : 8;
    L = 4 * (s + 1);
    ref_res = model(use_b ? fault_b : fault_a, use_b ? dly_b : dly_a, s);
    repeat (10) @(negedge clk);
    drive_start(use_b, 1'b1);
    @(negedge clk);
    drive_start(use_b, 1'b0);
    bad = 1'b0;
    for (int k = 0; k <= L; k++) begin
      v  = k / (s + 1);
      ea = (k < L && v >= 2) ? 4'hF : 4'h0;
      eb = (k < L && (v % 2) == 1) ? 4'hF : 4'h0;
      if (!bad && (o_busy !== (k < L) || o_done !== (k == L) || o_a !== ea || o_b !== eb)) begin
        bad = 1'b1;
        $display("FAIL run_timing k=%0d: busy=%b done=%b a=%h b=%h, required busy=%b done=%b a=%h b=%h",
                 k, o_busy, o_done, o_a, o_b, (k < L), (k == L), ea, eb);
      end
      st = (extra != 0) && (k == 4 || k == 19 || k >= L - 3);
      drive_start(use_b, st);
      if (k < L) @(negedge clk);
    end
    vectors++;
    if (bad) miscompares++;
    @(negedge clk);
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_done: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
    vectors++;
    if ({o_pass, o_mask, o_err, o_first} !== ref_res) begin
      miscompares++;
      $display("FAIL run_results: pass=%b mask=%b err=%0d first=%0d, required pass=%b mask=%b err=%0d first=%0d",
               o_pass, o_mask, o_err, o_first, ref_res[9], ref_res[8:5], ref_res[4:2], ref_res[1:0]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({a_out_a, b_out_a, busy_a, done_a, pass_a, fail_mask_a, err_a, first_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: a=%h b=%h busy=%b done=%b pass=%b mask=%b err=%0d first=%0d, required all 0",
               a_out_a, b_out_a, busy_a, done_a, pass_a, fail_mask_a, err_a, first_a);
    end
    vectors++;
    if ({a_out_b, b_out_b, busy_b, done_b, pass_b, fail_mask_b, err_b, first_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: a=%h b=%h busy=%b done=%b pass=%b mask=%b err=%0d first=%0d, required all 0",
               a_out_b, b_out_b, busy_b, done_b, pass_b, fail_mask_b, err_b, first_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input logic use_b, input logic [11:0] f, input int d, input logic [9:0] want, input string name);
    logic [9:0] r;
    if (use_b) begin fault_b = f; dly_b = d; end
    else begin fault_a = f; dly_a = d; end
    run_and_check(use_b, 0, r);
    vectors++;
    if ({o_pass, o_mask, o_err, o_first} !== want) begin
      miscompares++;
      $display("FAIL %s: pass=%b mask=%b err=%0d first=%0d, required pass=%b mask=%b err=%0d first=%0d",
               name, o_pass, o_mask, o_err, o_first, want[9], want[8:5], want[4:2], want[1:0]);
    end
  endtask

  task automatic test_start_ignored;
    logic [9:0] r;
    int n;
    fault_a = 12'b000_010_000_000;  // gate 2 stuck-at-1
    dly_a = 2;
    run_and_check(1'b0, 1, r);
    @(negedge clk);
    start_a = 1'b0;
    vectors++;
    if (o_busy !== 1'b1 || {o_pass, o_mask, o_err, o_first} !== 10'd0) begin
      miscompares++;
      $display("FAIL held_start_restart: busy=%b pass=%b mask=%b err=%0d first=%0d, required busy=1 and results 0",
               o_busy, o_pass, o_mask, o_err, o_first);
    end
    n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL second_run_done: no done within %0d cycles, required done", n);
    end
    @(negedge clk);
    vectors++;
    if ({o_pass, o_mask, o_err, o_first} !== {1'b0, 4'b0100, 3'd3, 2'd1}) begin
      miscompares++;
      $display("FAIL second_run_results: pass=%b mask=%b err=%0d first=%0d, required pass=0 mask=0100 err=3 first=1",
               o_pass, o_mask, o_err, o_first);
    end
  endtask

  task automatic test_reset_mid_run;
    logic seen;
    sel_b = 1'b0;
    fault_a = 12'b000_000_001_000;  // gate 1 stuck-at-0
    dly_a = 2;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (14) @(negedge clk);
    vectors++;
    if (o_busy !== 1'b1 || o_mask !== 4'b0010) begin
      miscompares++;
      $display("FAIL pre_reset: busy=%b mask=%b, required busy=1 mask=0010", o_busy, o_mask);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({o_a, o_b, o_busy, o_done, o_pass, o_mask, o_err, o_first} !== '0) begin
      miscompares++;
      $display("FAIL mid_run_reset: a=%h b=%h busy=%b done=%b pass=%b mask=%b err=%0d first=%0d, required all 0",
               o_a, o_b, o_busy, o_done, o_pass, o_mask, o_err, o_first);
    end
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_busy === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL no_done_after_reset: busy/done activity seen=%b, required 0", seen);
    end
  endtask

  task automatic test_random;
    logic [9:0] r;
    logic use_b;
    logic [11:0] f;
    for (int it = 0; it < 12; it++) begin
      use_b = 1'($urandom_range(0, 1));
      for (int g = 0; g < 4; g++) f[3*g +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      if (use_b) begin fault_b = f; dly_b = int'($urandom_range(1, 6)); end
      else begin fault_a = f; dly_a = int'($urandom_range(1, 8)); end
      run_and_check(use_b, 0, r);
    end
  endtask

  initial begin
    test_reset();
    test_directed(1'b0, 12'd0, 2, {1'b1, 4'b0000, 3'd0, 2'd0}, "ideal_nor");
    test_directed(1'b0, 12'b000_010_000_000, 2, {1'b0, 4'b0100, 3'd3, 2'd1}, "gate2_stuck1");
    test_directed(1'b0, 12'b011_000_000_001, 2, {1'b0, 4'b1001, 3'd4, 2'd0}, "gate0_stuck0_gate3_or");
    test_start_ignored();
    test_reset_mid_run();
    test_directed(1'b1, 12'd0, 2, {1'b1, 4'b0000, 3'd0, 2'd0}, "settle3_delay2");
    test_directed(1'b1, 12'd0, 5, {1'b0, 4'b1111, 3'd1, 2'd1}, "settle3_delay5");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
